// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: a direct-mapped I-cache refilled in bursts that feeds a circular instruction queue.
// Build option: define FETCH_BPRED_EN to let pred_taken/pred_offset steer the fetch PC.
//
// Refill FSM
//   state     | meaning
//   FILL_IDLE | no burst outstanding; a miss at pc starts one
//   FILL_REQ  | burst outstanding; returned words fill mem_addr + 4*burst_cnt
module inst_fetch_queue #(
    parameter int ICACHE_LINES = 512,
    parameter int IQ_DEPTH     = 8,
    parameter int BURST_LEN    = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        mem_abort,
    input  logic        mem_word_valid,
    input  logic [31:0] mem_word,
    input  logic        mem_done,
    output logic [31:0] pred_pc,
    output logic [31:0] pred_inst,
    input  logic        pred_taken,
    input  logic [31:0] pred_offset,
    input  logic        disp_full,
    output logic        disp_valid,
    output logic [31:0] disp_inst,
    output logic [31:0] disp_pc,
    output logic        disp_pred_taken,
    output logic [31:0] disp_fallthrough,
    input  logic        rollback,
    input  logic [31:0] rollback_pc
);

    localparam int IDX_W  = $clog2(ICACHE_LINES);
    localparam int PTR_W  = $clog2(IQ_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BCNT_W = $clog2(BURST_LEN + 1);

    typedef enum logic {
        FILL_IDLE,
        FILL_REQ
    } fill_state_t;

    fill_state_t        fill_state;
    logic [BCNT_W-1:0]  burst_cnt;

    logic [31:0]        pc;
    logic [31:0]        cache_data [ICACHE_LINES];
    logic [31:0]        cache_tag  [ICACHE_LINES];
    logic [ICACHE_LINES-1:0] cache_valid;

    logic [31:0]        iq_inst [IQ_DEPTH];
    logic [31:0]        iq_pc   [IQ_DEPTH];
    logic [31:0]        iq_fall [IQ_DEPTH];
    logic               iq_taken [IQ_DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;

    logic [IDX_W-1:0]   fetch_idx;
    logic               hit;
    logic [31:0]        fill_addr;
    logic [IDX_W-1:0]   fill_idx;
    logic               fill_we;
    logic               live;
    logic               enq;
    logic               deq;
    logic               take_branch;
    logic [31:0]        next_pc;

`ifdef FETCH_BPRED_EN
    assign take_branch = pred_taken;
`else
    logic unused_bpred;
    assign unused_bpred = ^{pred_taken, pred_offset};
    assign take_branch  = 1'b0;
`endif

    // Rollback pre-empts every enqueue, dequeue and fill in its cycle.
    assign live      = !rst_in && rdy_in && !rollback;

    assign fetch_idx = pc[IDX_W+1:2];
    assign hit       = cache_valid[fetch_idx] && (cache_tag[fetch_idx] == pc);

    assign fill_addr = mem_addr + 32'({burst_cnt, 2'b00});
    assign fill_idx  = fill_addr[IDX_W+1:2];
    assign fill_we   = live && (fill_state == FILL_REQ) && mem_word_valid;

    assign deq       = live && (count != '0) && !disp_full;
    assign enq       = live && hit && ((count < CNT_W'(IQ_DEPTH)) || deq);

    assign next_pc   = take_branch ? (pc + pred_offset) : (pc + 32'd4);

    assign pred_pc   = pc;
    assign pred_inst = hit ? cache_data[fetch_idx] : 32'd0;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pc <= 32'd0;
        end else if (rdy_in) begin
            if (rollback) begin
                pc <= rollback_pc;
            end else if (enq) begin
                pc <= next_pc;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            fill_state <= FILL_IDLE;
            burst_cnt  <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= 32'd0;
            mem_abort  <= 1'b0;
        end else if (!rdy_in) begin
            mem_abort <= 1'b0;
        end else begin
            mem_abort <= 1'b0;
            if (rollback) begin
                if (fill_state == FILL_REQ) begin
                    mem_abort <= 1'b1;
                end
                fill_state <= FILL_IDLE;
                mem_req    <= 1'b0;
                burst_cnt  <= '0;
            end else begin
                case (fill_state)
                    FILL_IDLE: begin
                        if (!hit) begin
                            fill_state <= FILL_REQ;
                            mem_req    <= 1'b1;
                            mem_addr   <= {pc[31:2], 2'b00};
                            burst_cnt  <= '0;
                        end
                    end
                    FILL_REQ: begin
                        if (mem_word_valid) begin
                            burst_cnt <= burst_cnt + BCNT_W'(1);
                        end
                        if (mem_done ||
                            (mem_word_valid && (burst_cnt == BCNT_W'(BURST_LEN - 1)))) begin
                            fill_state <= FILL_IDLE;
                            mem_req    <= 1'b0;
                        end
                    end
                    default: begin
                        fill_state <= FILL_IDLE;
                        mem_req    <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cache_valid <= '0;
        end else if (fill_we) begin
            cache_valid[fill_idx] <= 1'b1;
        end
    end

    // Data and tag arrays carry no reset; the valid bits gate every hit.
    always_ff @(posedge clk_in) begin
        if (fill_we) begin
            cache_data[fill_idx] <= mem_word;
            cache_tag[fill_idx]  <= fill_addr;
        end
    end

    always_ff @(posedge clk_in) begin
        if (enq) begin
            iq_inst[tail]  <= cache_data[fetch_idx];
            iq_pc[tail]    <= pc;
            iq_taken[tail] <= take_branch;
            iq_fall[tail]  <= pc + 32'd4;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            disp_valid       <= 1'b0;
            disp_inst        <= 32'd0;
            disp_pc          <= 32'd0;
            disp_pred_taken  <= 1'b0;
            disp_fallthrough <= 32'd0;
        end else if (rdy_in) begin
            if (rollback) begin
                head       <= '0;
                tail       <= '0;
                count      <= '0;
                disp_valid <= 1'b0;
            end else begin
                if (enq) begin
                    tail <= tail + PTR_W'(1);
                end
                if (deq) begin
                    head             <= head + PTR_W'(1);
                    disp_valid       <= 1'b1;
                    disp_inst        <= iq_inst[head];
                    disp_pc          <= iq_pc[head];
                    disp_pred_taken  <= iq_taken[head];
                    disp_fallthrough <= iq_fall[head];
                end else begin
                    disp_valid <= 1'b0;
                end
                case ({enq, deq})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed scenarios then random traffic, checked against a program-path scoreboard.
module tb_inst_fetch_queue;

    localparam int ICACHE_LINES = 512;
    localparam int IQ_DEPTH     = 8;
    localparam int BURST_LEN    = 8;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_abort;
    logic        mem_word_valid;
    logic [31:0] mem_word;
    logic        mem_done;
    logic [31:0] pred_pc;
    logic [31:0] pred_inst;
    logic        pred_taken;
    logic [31:0] pred_offset;
    logic        disp_full;
    logic        disp_valid;
    logic [31:0] disp_inst;
    logic [31:0] disp_pc;
    logic        disp_pred_taken;
    logic [31:0] disp_fallthrough;
    logic        rollback;
    logic [31:0] rollback_pc;

    always #5 clk_in = ~clk_in;

    inst_fetch_queue #(
        .ICACHE_LINES(ICACHE_LINES),
        .IQ_DEPTH(IQ_DEPTH),
        .BURST_LEN(BURST_LEN)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .rdy_in(rdy_in),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_abort(mem_abort),
        .mem_word_valid(mem_word_valid),
        .mem_word(mem_word),
        .mem_done(mem_done),
        .pred_pc(pred_pc),
        .pred_inst(pred_inst),
        .pred_taken(pred_taken),
        .pred_offset(pred_offset),
        .disp_full(disp_full),
        .disp_valid(disp_valid),
        .disp_inst(disp_inst),
        .disp_pc(disp_pc),
        .disp_pred_taken(disp_pred_taken),
        .disp_fallthrough(disp_fallthrough),
        .rollback(rollback),
        .rollback_pc(rollback_pc)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: next PC the program path must dispatch, and the memory side of the burst.
    logic [31:0] exp_pc;
    bit          m_burst;
    int          m_cnt;
    logic [31:0] m_addr;
    int          ndisp;
    int          rv_pct;
    int          done_at;
    int          done_pct;
    bit          want_rb;
    logic [31:0] want_rb_pc;
    bit          saw10;
    logic        saw10_taken;

    localparam logic [31:0] GARBAGE = 32'hDEAD_BEE0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return ((a * 32'h9E37_79B1) ^ 32'h0BAD_F00D) | 32'h1;
    endfunction

    function automatic logic taken_f(input logic [31:0] pc);
        logic [31:0] h;
        h = mem_f(pc);
        if (pc == 32'h10) return 1'b1;
        return (pc >= 32'h8000) && (h[7:4] == 4'h0);
    endfunction

    function automatic logic [31:0] off_f(input logic [31:0] pc);
        logic [31:0] h;
        if (pc == 32'h10) return 32'hFFFF_FFF0;
        h = mem_f(pc ^ 32'h55);
        return {{24{h[15]}}, h[15:10], 2'b00};
    endfunction

    function automatic logic exp_taken_f(input logic [31:0] pc);
`ifdef FETCH_BPRED_EN
        return taken_f(pc);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] next_f(input logic [31:0] pc);
        return exp_taken_f(pc) ? pc + off_f(pc) : pc + 32'd4;
    endfunction

    task automatic tick();
        logic        s_req, s_dv, s_dt;
        logic [31:0] s_addr, s_pc, s_di, s_dp, s_df;
        pred_taken     = taken_f(pred_pc);
        pred_offset    = off_f(pred_pc);
        rollback       = want_rb;
        rollback_pc    = want_rb_pc;
        mem_word_valid = 1'b0;
        mem_done       = 1'b0;
        mem_word       = GARBAGE;
        if (m_burst) begin
            if ($urandom_range(0, 99) < rv_pct) begin
                mem_word_valid = 1'b1;
                if (rdy_in && !want_rb) mem_word = mem_f(m_addr + 32'(m_cnt) * 4);
                if (done_at != 0 && m_cnt + 1 == done_at) mem_done = 1'b1;
            end
            if (done_pct != 0 && $urandom_range(0, 99) < done_pct) mem_done = 1'b1;
        end
        s_req = mem_req;  s_addr = mem_addr; s_pc = pred_pc;  s_dv = disp_valid;
        s_di = disp_inst; s_dp = disp_pc;    s_dt = disp_pred_taken; s_df = disp_fallthrough;
        @(posedge clk_in);
        #1;
        if (!rdy_in) begin
            chk("hold_abort", mem_abort, 0);
            chk("hold_req", mem_req, s_req);
            chk("hold_addr", mem_addr, s_addr);
            chk("hold_pc", pred_pc, s_pc);
            chk("hold_dv", disp_valid, s_dv);
            chk("hold_di", disp_inst, s_di);
            chk("hold_dp", disp_pc, s_dp);
            chk("hold_dt", disp_pred_taken, s_dt);
            chk("hold_df", disp_fallthrough, s_df);
        end else if (rollback) begin
            chk("rb_abort", mem_abort, m_burst);
            chk("rb_req", mem_req, 0);
            chk("rb_disp_valid", disp_valid, 0);
            chk("rb_pc", pred_pc, rollback_pc);
            m_burst = 0;
            exp_pc  = rollback_pc;
        end else begin
            chk("abort_quiet", mem_abort, 0);
            if (disp_full) chk("full_no_disp", disp_valid, 0);
            if (disp_valid) begin
                chk("disp_pc", disp_pc, exp_pc);
                chk("disp_inst", disp_inst, mem_f(exp_pc));
                chk("disp_fall", disp_fallthrough, exp_pc + 32'd4);
                chk("disp_taken", disp_pred_taken, exp_taken_f(exp_pc));
                if (exp_pc == 32'h10) begin
                    saw10       = 1;
                    saw10_taken = disp_pred_taken;
                end
                exp_pc = next_f(exp_pc);
                ndisp++;
            end
            if (m_burst) begin
                if (mem_word_valid) m_cnt++;
                if (m_cnt == BURST_LEN || mem_done) m_burst = 0;
                chk("burst_req", mem_req, m_burst);
                if (m_burst) chk("burst_addr", mem_addr, m_addr);
            end else if (mem_req) begin
                chk("miss_addr", mem_addr, s_pc & ~32'd3);
                m_burst = 1;
                m_cnt   = 0;
                m_addr  = mem_addr;
            end
        end
    endtask

    task automatic do_rollback(input logic [31:0] target);
        want_rb    = 1;
        want_rb_pc = target;
        tick();
        want_rb    = 0;
    endtask

    initial begin
        logic [31:0] p;
        int          n0;
        rst_in = 1; rdy_in = 0; disp_full = 0; rollback = 0; rollback_pc = 0;
        mem_word_valid = 0; mem_word = 0; mem_done = 0; pred_taken = 0; pred_offset = 0;
        exp_pc = 0; m_burst = 0; m_cnt = 0; m_addr = 0; ndisp = 0;
        rv_pct = 100; done_at = 0; done_pct = 0; want_rb = 0; want_rb_pc = 0;
        saw10 = 0; saw10_taken = 0;

        // Reset with rdy_in low: reset must still win.
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_req", mem_req, 0);
        chk("rst_abort", mem_abort, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_dv", disp_valid, 0);
        chk("rst_di", disp_inst, 0);
        chk("rst_dp", disp_pc, 0);
        chk("rst_dt", disp_pred_taken, 0);
        chk("rst_df", disp_fallthrough, 0);
        chk("rst_pc", pred_pc, 0);
        chk("rst_pinst", pred_inst, 0);
        rst_in = 0;
        rdy_in = 1;

        // 4-word burst at 0 ended by mem_done, then the miss at 0x10 waits for memory.
        done_at = 4;
        tick();
        chk("t1_req", mem_req, 1);
        chk("t1_addr", mem_addr, 0);
        for (int i = 0; i < 11; i++) begin
            rv_pct = (m_burst && m_addr == 32'h0) ? 100 : 0;
            tick();
        end
        chk("t1_ndisp", ndisp, 4);
        chk("t1_req2", mem_req, 1);
        chk("t1_addr2", mem_addr, 32'h10);

        // Branch at 0x10 predicted taken back to 0.
        rv_pct = 100; done_at = 0;
        repeat (30) tick();
        chk("t2_saw10", saw10, 1);
        chk("t2_taken10", saw10_taken, exp_taken_f(32'h10));

        // Queue saturates while dispatch is blocked, then drains in order.
        disp_full = 1;
        do_rollback(32'h0);
        repeat (20) tick();
        p = 0;
        repeat (IQ_DEPTH) p = next_f(p);
        chk("t3_pc_stall", pred_pc, p);
        n0 = ndisp;
        disp_full = 0;
        repeat (IQ_DEPTH) tick();
        chk("t3_drain", ndisp - n0, IQ_DEPTH);

        // Rollback after 3 words of a burst; the 4th word on that cycle is garbage and must be dropped.
        do_rollback(32'h2000);
        tick();
        chk("t4_addr0", mem_addr, 32'h2000);
        repeat (3) tick();
        do_rollback(32'h100);
        chk("t4_abort", mem_abort, 1);
        tick();
        chk("t4_abort_clear", mem_abort, 0);
        chk("t4_req", mem_req, 1);
        chk("t4_addr", mem_addr, 32'h100);
        repeat (10) tick();
        do_rollback(32'h200C);
        tick();
        chk("t4_dropped_req", mem_req, 1);
        chk("t4_dropped_addr", mem_addr, 32'h200C);

        // Early end after 2 words; the next miss restarts at word 2.
        do_rollback(32'h3000);
        tick();
        chk("t5_addr0", mem_addr, 32'h3000);
        done_at = 2;
        repeat (2) tick();
        chk("t5_done_req", mem_req, 0);
        done_at = 0;
        for (int i = 0; i < 10 && !mem_req; i++) tick();
        chk("t5_req", mem_req, 1);
        chk("t5_addr", mem_addr, 32'h3008);

        // rdy_in low for 5 cycles mid-burst.
        do_rollback(32'h4000);
        tick();
        repeat (3) tick();
        rdy_in = 0;
        repeat (5) tick();
        rdy_in = 1;
        repeat (20) tick();
        chk("t6_progress", exp_pc >= 32'h4020, 1);

        // Random traffic, including aliasing regions for the full-tag compare.
        rv_pct = 70; done_pct = 4;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] base;
            rdy_in    = ($urandom_range(0, 99) < 95);
            disp_full = ($urandom_range(0, 99) < 30);
            want_rb   = ($urandom_range(0, 99) < 3);
            case ($urandom_range(0, 3))
                0:       base = 32'h0;
                1:       base = 32'h2000;
                2:       base = 32'h8000;
                default: base = 32'h8800;
            endcase
            want_rb_pc = base + 32'($urandom_range(0, 127)) * 4;
            tick();
        end
        want_rb = 0; rdy_in = 1; disp_full = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
